// File: rtl/mask_index_scanner.sv
// mask_index_scanner: walks the set bits of a validity mask word in ascending order, one index per cycle
module mask_index_scanner #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic                  mask_vld,
  input  logic [DATA_WIDTH-1:0] mask_data,
  output logic                  mask_rdy,
  output logic                  idx_vld,
  output logic [IDX_WIDTH-1:0]  idx,
  output logic                  idx_last,
  input  logic                  idx_rdy,
  output logic                  scan_done,
  output logic [IDX_WIDTH:0]    nz_count
);
  typedef enum logic {IDLE, SCAN} state_t;
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] pend_q, pend_d, pend_nxt;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic                  last_q, last_d, done_q, done_d;
  logic [IDX_WIDTH:0]    cnt_q, cnt_d;
  function automatic logic [IDX_WIDTH-1:0] lowest(input logic [DATA_WIDTH-1:0] p);
    logic [IDX_WIDTH-1:0] r;
    r = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) if (p[i]) r = IDX_WIDTH'(i);
    return r;
  endfunction
  function automatic logic single(input logic [DATA_WIDTH-1:0] p);
    return (p != '0) && ((p & (p - DATA_WIDTH'(1))) == '0);
  endfunction
  // idx/idx_last are registered so they hold once the word is exhausted
  always_comb begin
    pend_nxt = pend_q & (pend_q - DATA_WIDTH'(1));
    state_d  = state_q;
    pend_d   = pend_q;
    idx_d    = idx_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    if (state_q == IDLE) begin
      if (mask_vld) begin
        pend_d = mask_data;
        cnt_d  = '0;
        done_d = (mask_data == '0);
        if (mask_data != '0) begin
          state_d = SCAN;
          idx_d   = lowest(mask_data);
          last_d  = single(mask_data);
        end
      end
    end else if (idx_rdy) begin
      pend_d  = pend_nxt;
      cnt_d   = cnt_q + (IDX_WIDTH+1)'(1);
      done_d  = last_q;
      state_d = last_q ? IDLE : SCAN;
      if (!last_q) begin
        idx_d  = lowest(pend_nxt);
        last_d = single(pend_nxt);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (clk_en) begin
      state_q <= state_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end
  assign mask_rdy  = (state_q == IDLE);
  assign idx_vld   = (state_q == SCAN);
  assign idx       = idx_q;
  assign idx_last  = last_q;
  assign scan_done = done_q;
  assign nz_count  = cnt_q;
endmodule

// File: tb/tb_mask_index_scanner.sv
// tb_mask_index_scanner: directed and randomized checks of the mask index scanner
module tb_mask_index_scanner;
  localparam int W = 16;
  localparam int IW = 4;
  logic clk = 1'b0;
  logic rst, clk_en, mask_vld, idx_rdy;
  logic [W-1:0] mask_data;
  logic mask_rdy, idx_vld, idx_last, scan_done;
  logic [IW-1:0] idx;
  logic [IW:0] nz_count;
  int n_cmp = 0;
  int n_err = 0;
  int got_idx[$];
  bit got_last[$];
  int got_cnt[$];
  int exp_idx[$];
  bit exp_last[$];
  int exp_cnt[$];
  bit stop_rdy;

  mask_index_scanner #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .mask_vld(mask_vld), .mask_data(mask_data),
    .mask_rdy(mask_rdy), .idx_vld(idx_vld), .idx(idx), .idx_last(idx_last),
    .idx_rdy(idx_rdy), .scan_done(scan_done), .nz_count(nz_count)
  );

  always #5 clk = ~clk;

  // records every completed handshake and completion pulse
  always @(negedge clk) begin
    if (!rst && clk_en && idx_vld && idx_rdy) begin
      got_idx.push_back(int'(idx));
      got_last.push_back(idx_last);
    end
    if (scan_done && clk_en) got_cnt.push_back(int'(nz_count));
  end

  // reference: the set bits of a word, ascending, with the top one marked last
  function automatic void add_word(input logic [W-1:0] m);
    int hi;
    hi = -1;
    for (int i = 0; i < W; i++) if (m[i]) hi = i;
    for (int i = 0; i < W; i++)
      if (m[i]) begin
        exp_idx.push_back(i);
        exp_last.push_back(i == hi);
      end
    exp_cnt.push_back($countones(m));
  endfunction

  task automatic clear_q();
    got_idx.delete(); got_last.delete(); got_cnt.delete();
    exp_idx.delete(); exp_last.delete(); exp_cnt.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] m);
    bit ok;
    ok = 0;
    mask_data = m;
    mask_vld = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (mask_rdy && clk_en && !rst) ok = 1;
      @(posedge clk); #1;
    end
    mask_vld = 1'b0;
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL send_timeout: mask %h accepted=%0d required=1", m, ok); end
  endtask

  task automatic test_reset();
    rst = 1'b1; clk_en = 1'b1; mask_vld = 1'b0; mask_data = '0; idx_rdy = 1'b0;
    idle(3);
    @(negedge clk);
    n_cmp++;
    if ({mask_rdy, idx_vld, idx, idx_last, scan_done, nz_count} !== {1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 5'd0}) begin
      n_err++; $display("FAIL reset_state: got %b required %b", {mask_rdy, idx_vld, idx, idx_last, scan_done, nz_count}, 13'b1_0_0000_0_0_00000);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({mask_rdy, idx_vld, scan_done, nz_count} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin
      n_err++; $display("FAIL post_reset_idle: got %b required 10000000", {mask_rdy, idx_vld, scan_done, nz_count});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_word();
    clear_q();
    send(16'h0000);
    @(negedge clk);
    n_cmp++;
    if ({mask_rdy, idx_vld, scan_done, nz_count} !== {1'b1, 1'b0, 1'b1, 5'd0}) begin
      n_err++; $display("FAIL zero_done: got %b required 10100000", {mask_rdy, idx_vld, scan_done, nz_count});
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({mask_rdy, idx_vld, scan_done} !== 3'b100 || got_idx.size() != 0) begin
      n_err++; $display("FAIL zero_pulse_width: got %b idx_count %0d required 100 idx_count 0", {mask_rdy, idx_vld, scan_done}, got_idx.size());
    end
    idle(1);
  endtask

  task automatic test_sparse_word();
    clear_q();
    idx_rdy = 1'b1;
    add_word(16'h8421);
    send(16'h8421);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({mask_rdy, idx_vld, idx, idx_last} !== {1'b0, 1'b1, IW'(exp_idx[k]), exp_last[k]}) begin
        n_err++; $display("FAIL sparse_idx%0d: got idx=%0d vld=%b last=%b rdy=%b required idx=%0d vld=1 last=%b rdy=0",
          k, idx, idx_vld, idx_last, mask_rdy, exp_idx[k], exp_last[k]);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_cmp++;
    if ({mask_rdy, idx_vld, scan_done, nz_count} !== {1'b1, 1'b0, 1'b1, 5'd4}) begin
      n_err++; $display("FAIL sparse_done: got %b required 10100100", {mask_rdy, idx_vld, scan_done, nz_count});
    end
    idle(2);
  endtask

  task automatic test_backpressure();
    int k;
    int t;
    clear_q();
    idx_rdy = 1'b0;
    send(16'hFFFF);
    k = 0;
    for (t = 0; t < 80; t++) begin
      idx_rdy = ~idx_rdy;
      @(negedge clk);
      if (scan_done) break;
      if (idx_vld) begin
        n_cmp++;
        if (idx !== IW'(k) || idx_last !== (k == 15)) begin
          n_err++; $display("FAIL full_idx: got idx=%0d last=%b required idx=%0d last=%b", idx, idx_last, k, (k == 15));
        end
        if (idx_rdy) k++;
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (k != 16 || !scan_done || nz_count !== 5'b10000) begin
      n_err++; $display("FAIL full_count: got accepted=%0d done=%b nz=%0d required accepted=16 done=1 nz=16", k, scan_done, nz_count);
    end
    idx_rdy = 1'b1;
    idle(2);
  endtask

  task automatic test_back_to_back();
    logic [2:0] ctl [6] = '{3'b100, 3'b010, 3'b010, 3'b101, 3'b010, 3'b101};
    int ix [6] = '{0, 0, 1, 0, 8, 0};
    bit lst [6] = '{0, 0, 1, 0, 1, 0};
    idx_rdy = 1'b1;
    mask_data = 16'h0003; mask_vld = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({mask_rdy, idx_vld, scan_done} !== ctl[c] || (ctl[c][1] && {idx, idx_last} !== {IW'(ix[c]), lst[c]})) begin
        n_err++; $display("FAIL b2b_cycle%0d: got rdy/vld/done=%b idx=%0d last=%b required %b idx=%0d last=%b",
          c, {mask_rdy, idx_vld, scan_done}, idx, idx_last, ctl[c], ix[c], lst[c]);
      end
      if (c == 5) begin
        n_cmp++;
        if (nz_count !== 5'd1) begin n_err++; $display("FAIL b2b_count: got %0d required 1", nz_count); end
      end
      @(posedge clk); #1;
      if (c == 0) mask_data = 16'h0100;
      if (c == 3) mask_vld = 1'b0;
    end
    idle(1);
  endtask

  task automatic test_reset_mid_scan();
    int t;
    clear_q();
    idx_rdy = 1'b1;
    send(16'h00F0);
    idle(2);
    rst = 1'b1; clk_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; clk_en = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({mask_rdy, idx_vld, scan_done, nz_count} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin
      n_err++; $display("FAIL midreset_state: got %b required 10000000", {mask_rdy, idx_vld, scan_done, nz_count});
    end
    idle(3);
    n_cmp++;
    if (got_cnt.size() != 0 || got_idx.size() != 2) begin
      n_err++; $display("FAIL midreset_no_done: got done=%0d idx=%0d required done=0 idx=2", got_cnt.size(), got_idx.size());
    end
    clear_q();
    add_word(16'h0006);
    send(16'h0006);
    t = 0;
    do begin @(negedge clk); t++; end while (!scan_done && t < 50);
    n_cmp++;
    if (!scan_done || got_idx.size() != 2 || got_idx[0] != exp_idx[0] || got_idx[1] != exp_idx[1] || nz_count !== 5'd2) begin
      n_err++; $display("FAIL midreset_rescan: got done=%b n=%0d nz=%0d required done=1 idx 1,2 nz=2", scan_done, got_idx.size(), nz_count);
    end
    idle(2);
  endtask

  task automatic test_clk_en();
    int t;
    clear_q();
    idx_rdy = 1'b1;
    send(16'h0011);
    clk_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({idx_vld, idx} !== {1'b1, 4'd0}) begin
        n_err++; $display("FAIL clken_hold%0d: got vld=%b idx=%0d required vld=1 idx=0", c, idx_vld, idx);
      end
      @(posedge clk); #1;
    end
    clk_en = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({idx_vld, idx, idx_last} !== {1'b1, 4'd4, 1'b1}) begin
      n_err++; $display("FAIL clken_resume: got vld=%b idx=%0d last=%b required vld=1 idx=4 last=1", idx_vld, idx, idx_last);
    end
    t = 0;
    do begin @(posedge clk); #1; @(negedge clk); t++; end while (!scan_done && t < 20);
    n_cmp++;
    if (got_idx.size() != 2 || got_idx[0] != 0 || got_idx[1] != 4 || nz_count !== 5'd2) begin
      n_err++; $display("FAIL clken_seq: got n=%0d nz=%0d required idx 0,4 nz=2", got_idx.size(), nz_count);
    end
    idle(2);
  endtask

  task automatic test_random();
    logic [W-1:0] m;
    int t;
    clear_q();
    stop_rdy = 0;
    fork
      while (!stop_rdy) begin
        @(posedge clk); #1;
        idx_rdy = 1'($urandom_range(0, 1));
      end
    join_none
    for (int w = 0; w < 40; w++) begin
      case ($urandom_range(0, 3))
        0: m = '0;
        1: m = W'($urandom) & W'($urandom) & W'($urandom);
        2: m = W'(1) << $urandom_range(0, W - 1);
        default: m = W'($urandom);
      endcase
      add_word(m);
      send(m);
    end
    t = 0;
    while (got_cnt.size() < 40 && t < 3000) begin @(negedge clk); t++; end
    stop_rdy = 1;
    idle(2);
    idx_rdy = 1'b1;
    n_cmp++;
    if (got_cnt.size() != exp_cnt.size() || got_idx.size() != exp_idx.size()) begin
      n_err++; $display("FAIL rand_sizes: got words=%0d idx=%0d required words=%0d idx=%0d", got_cnt.size(), got_idx.size(), exp_cnt.size(), exp_idx.size());
    end
    for (int i = 0; i < exp_idx.size() && i < got_idx.size(); i++) begin
      n_cmp++;
      if (got_idx[i] != exp_idx[i] || got_last[i] != exp_last[i]) begin
        n_err++; $display("FAIL rand_idx%0d: got idx=%0d last=%b required idx=%0d last=%b", i, got_idx[i], got_last[i], exp_idx[i], exp_last[i]);
      end
    end
    for (int i = 0; i < exp_cnt.size() && i < got_cnt.size(); i++) begin
      n_cmp++;
      if (got_cnt[i] != exp_cnt[i]) begin
        n_err++; $display("FAIL rand_count%0d: got %0d required %0d", i, got_cnt[i], exp_cnt[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_word();
    test_sparse_word();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_scan();
    test_clk_en();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
